// File: rtl/alu_addsub_seq.sv
// Multi-cycle add/subtract unit: CHUNK bits per clock with a registered carry,
// start/busy/done handshake, and carry/overflow/zero flags on the final result.
module alu_addsub_seq #(
  parameter int WIDTH = 32,
  parameter int CHUNK = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             mode,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  output logic [WIDTH-1:0] Sum,
  output logic             cOut,
  output logic             overflow,
  output logic             zero,
  output logic             busy,
  output logic             done
);

  localparam int NCHUNK = WIDTH / CHUNK;
  localparam int IDX_W  = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NCHUNK - 1);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t           state_q, state_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic [WIDTH-1:0] opa_q, opa_d;
  logic [WIDTH-1:0] opb_q, opb_d;
  logic [WIDTH-1:0] sum_q, sum_d;
  logic             carry_q, carry_d;
  logic             cout_q, cout_d;
  logic             ovf_q, ovf_d;
  logic             zero_q, zero_d;
  logic [CHUNK:0]   chunk_res;

  function automatic logic [CHUNK-1:0] get_chunk(input logic [WIDTH-1:0] vec,
                                                 input logic [IDX_W-1:0] idx);
    return CHUNK'(vec >> (int'(idx) * CHUNK));
  endfunction

  // Replace only chunk idx; every other bit of vec passes through untouched.
  function automatic logic [WIDTH-1:0] put_chunk(input logic [WIDTH-1:0] vec,
                                                 input logic [IDX_W-1:0] idx,
                                                 input logic [CHUNK-1:0] val);
    logic [WIDTH-1:0] mask;
    int               sh;
    sh   = int'(idx) * CHUNK;
    mask = WIDTH'({CHUNK{1'b1}}) << sh;
    return (vec & ~mask) | (WIDTH'(val) << sh);
  endfunction

  function automatic logic [CHUNK:0] add_chunk(input logic [CHUNK-1:0] a,
                                               input logic [CHUNK-1:0] b,
                                               input logic             cin);
    return {1'b0, a} + {1'b0, b} + (CHUNK+1)'(cin);
  endfunction

  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    opa_d     = opa_q;
    opb_d     = opb_q;
    sum_d     = sum_q;
    carry_d   = carry_q;
    cout_d    = cout_q;
    ovf_d     = ovf_q;
    zero_d    = zero_q;
    chunk_res = add_chunk(get_chunk(opa_q, idx_q), get_chunk(opb_q, idx_q), carry_q);

    case (state_q)
      IDLE, DONE: begin
        if (start) begin
          // Subtract is A + ~B + 1: invert B here and seed the carry with mode.
          opa_d   = A;
          opb_d   = mode ? ~B : B;
          carry_d = mode;
          idx_d   = '0;
          state_d = RUN;
        end else begin
          state_d = IDLE;
        end
      end
      RUN: begin
        sum_d   = put_chunk(sum_q, idx_q, chunk_res[CHUNK-1:0]);
        carry_d = chunk_res[CHUNK];
        idx_d   = idx_q + 1'b1;
        if (idx_q == LAST_IDX) begin
          cout_d  = chunk_res[CHUNK];
          ovf_d   = (opa_q[WIDTH-1] == opb_q[WIDTH-1]) &&
                    (sum_d[WIDTH-1] != opa_q[WIDTH-1]);
          zero_d  = (sum_d == '0);
          idx_d   = '0;
          state_d = DONE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      idx_q   <= '0;
      sum_q   <= '0;
      cout_q  <= 1'b0;
      ovf_q   <= 1'b0;
      zero_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      sum_q   <= sum_d;
      cout_q  <= cout_d;
      ovf_q   <= ovf_d;
      zero_q  <= zero_d;
    end
  end

  // Operand and carry registers are always reloaded on start, so they need no reset.
  always_ff @(posedge clk) begin
    opa_q   <= opa_d;
    opb_q   <= opb_d;
    carry_q <= carry_d;
  end

  assign Sum      = sum_q;
  assign cOut     = cout_q;
  assign overflow = ovf_q;
  assign zero     = zero_q;
  assign busy     = (state_q == RUN);
  assign done     = (state_q == DONE);

endmodule
